// File: rtl/axi_lite_to_tcdm.sv
// AXI-lite slave to TCDM master bridge, one transaction in flight at a time.
// Optional address window check (DECERR outside the window): define AXI2TCDM_RANGE_CHECK_EN.
package axi_lite_to_tcdm_pkg;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid;
    logic        r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } axi_lite_resp_t;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } tcdm_req_t;

  typedef struct packed {
    logic        gnt;
    logic        r_opc;
    logic [31:0] r_rdata;
    logic        r_valid;
  } tcdm_rsp_t;

endpackage

module axi_lite_to_tcdm
  import axi_lite_to_tcdm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] REGION_SIZE = 32'h0001_0000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  axi_lite_req_t  axi_req_i,
  output axi_lite_resp_t axi_rsp_o,
  output tcdm_req_t      tcdm_req_o,
  input  tcdm_rsp_t      tcdm_rsp_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TREQ  = 3'd1,
    S_TWAIT = 3'd2,
    S_BRESP = 3'd3,
    S_RRESP = 3'd4
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_wr_pend;
  logic        w_rd_pend;
  logic        w_pick_wr;
  logic        w_pick_rd;
  logic        w_in_range;
  logic [31:0] w_acc_addr;
  logic [31:0] w_off;
  logic        w_unused;

  logic        r_is_wr;
  logic        r_prio_rd;
  logic        r_wen;
  logic [31:0] r_add;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_be;
  logic [1:0]  r_resp;

  // Readies are gated by rst_ni so nothing is offered while reset is held.
  assign w_wr_pend  = rst_ni & axi_req_i.aw_valid & axi_req_i.w_valid;
  assign w_rd_pend  = rst_ni & axi_req_i.ar_valid;
  assign w_pick_wr  = (r_state == S_IDLE) & w_wr_pend & (~w_rd_pend | ~r_prio_rd);
  assign w_pick_rd  = (r_state == S_IDLE) & w_rd_pend & ~w_pick_wr;
  assign w_acc_addr = w_pick_wr ? axi_req_i.aw_addr : axi_req_i.ar_addr;
  assign w_off      = w_acc_addr - BASE_ADDR;
  assign w_unused   = ^{axi_req_i.aw_prot, axi_req_i.ar_prot, REGION_SIZE};

`ifdef AXI2TCDM_RANGE_CHECK_EN
  assign w_in_range = (w_off < REGION_SIZE);
`else
  assign w_in_range = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_wr) begin
          w_state_nxt = w_in_range ? S_TREQ : S_BRESP;
        end else if (w_pick_rd) begin
          w_state_nxt = w_in_range ? S_TREQ : S_RRESP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TREQ: begin
        if (tcdm_rsp_i.gnt) begin
          w_state_nxt = S_TWAIT;
        end else begin
          w_state_nxt = S_TREQ;
        end
      end
      S_TWAIT: begin
        if (tcdm_rsp_i.r_valid) begin
          w_state_nxt = r_is_wr ? S_BRESP : S_RRESP;
        end else begin
          w_state_nxt = S_TWAIT;
        end
      end
      S_BRESP: begin
        if (axi_req_i.b_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BRESP;
        end
      end
      S_RRESP: begin
        if (axi_req_i.r_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RRESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture at accept, response capture on the first r_valid in TWAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_is_wr   <= 1'b0;
      r_prio_rd <= 1'b0;
      r_wen     <= 1'b1;
      r_add     <= 32'h0000_0000;
      r_wdata   <= 32'h0000_0000;
      r_be      <= 4'h0;
      r_resp    <= 2'b00;
      r_rdata   <= 32'h0000_0000;
    end else if (w_pick_wr | w_pick_rd) begin
      r_is_wr   <= w_pick_wr;
      r_prio_rd <= w_pick_wr;
      r_wen     <= ~w_pick_wr;
      r_add     <= w_off;
      r_wdata   <= w_pick_wr ? axi_req_i.w_data : 32'h0000_0000;
      r_be      <= w_pick_wr ? axi_req_i.w_strb : 4'hF;
      if (!w_in_range) begin
        r_resp  <= 2'b11;
        r_rdata <= 32'h0000_0000;
      end else begin
        r_resp  <= r_resp;
        r_rdata <= r_rdata;
      end
    end else if ((r_state == S_TWAIT) && tcdm_rsp_i.r_valid) begin
      r_resp <= tcdm_rsp_i.r_opc ? 2'b10 : 2'b00;
      if (!r_is_wr) begin
        r_rdata <= tcdm_rsp_i.r_rdata;
      end else begin
        r_rdata <= r_rdata;
      end
    end else begin
      r_resp  <= r_resp;
      r_rdata <= r_rdata;
    end
  end

  // Output assembly from registers and state decode.
  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = w_pick_wr;
    axi_rsp_o.w_ready  = w_pick_wr;
    axi_rsp_o.ar_ready = w_pick_rd;
    axi_rsp_o.b_valid  = (r_state == S_BRESP);
    axi_rsp_o.b_resp   = r_resp;
    axi_rsp_o.r_valid  = (r_state == S_RRESP);
    axi_rsp_o.r_resp   = r_resp;
    axi_rsp_o.r_data   = r_rdata;
    tcdm_req_o         = '0;
    tcdm_req_o.req     = (r_state == S_TREQ);
    tcdm_req_o.add     = r_add;
    tcdm_req_o.wen     = r_wen;
    tcdm_req_o.wdata   = r_wdata;
    tcdm_req_o.be      = r_be;
  end

endmodule

// File: tb/tb_axi_lite_to_tcdm.sv
// Scoreboard bench for axi_lite_to_tcdm: directed AXI-lite traffic against a TCDM responder model.
module tb_axi_lite_to_tcdm;
  import axi_lite_to_tcdm_pkg::*;

`ifdef AXI2TCDM_RANGE_CHECK_EN
  localparam logic [31:0] TB_BASE = 32'h0000_1000;
  localparam logic [31:0] TB_SIZE = 32'h0000_0100;
`else
  localparam logic [31:0] TB_BASE = 32'h0000_0000;
  localparam logic [31:0] TB_SIZE = 32'h0001_0000;
`endif

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;
  } treq_t;

  typedef struct {
    logic        is_wr;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  axi_lite_req_t  axi_req;
  axi_lite_resp_t axi_rsp;
  tcdm_req_t      tcdm_req;
  tcdm_rsp_t      tcdm_rsp;

  logic [31:0] aw_addr_s = 32'h0, w_data_s = 32'h0, ar_addr_s = 32'h0, r_rdata_s = 32'h0;
  logic [3:0]  w_strb_s = 4'h0;
  logic        aw_valid_s = 1'b0, w_valid_s = 1'b0, ar_valid_s = 1'b0;
  logic        b_ready_s = 1'b1, r_ready_s = 1'b1;
  logic        gnt_s = 1'b0, r_opc_s = 1'b0, r_valid_s = 1'b0;

  int          gnt_delay = 0, r_stall = 0, b_stall = 0;
  bit          rv_block = 1'b0;
  logic        cur_opc = 1'b0;
  logic [31:0] cur_rdata = 32'h0;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  treq_t  treq_q[$];
  rsp_t   rsp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    axi_req          = '0;
    axi_req.aw_addr  = aw_addr_s;
    axi_req.aw_prot  = 3'b111;
    axi_req.aw_valid = aw_valid_s;
    axi_req.w_data   = w_data_s;
    axi_req.w_strb   = w_strb_s;
    axi_req.w_valid  = w_valid_s;
    axi_req.b_ready  = b_ready_s;
    axi_req.ar_addr  = ar_addr_s;
    axi_req.ar_prot  = 3'b101;
    axi_req.ar_valid = ar_valid_s;
    axi_req.r_ready  = r_ready_s;
    tcdm_rsp         = '0;
    tcdm_rsp.gnt     = gnt_s;
    tcdm_rsp.r_opc   = r_opc_s;
    tcdm_rsp.r_rdata = r_rdata_s;
    tcdm_rsp.r_valid = r_valid_s;
  end

  axi_lite_to_tcdm #(.BASE_ADDR(TB_BASE), .REGION_SIZE(TB_SIZE)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .axi_req_i  (axi_req),
    .axi_rsp_o  (axi_rsp),
    .tcdm_req_o (tcdm_req),
    .tcdm_rsp_i (tcdm_rsp)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // TCDM responder: grants after gnt_delay extra cycles, r_valid the cycle after the grant.
  initial begin : tcdm_model
    int  req_cnt;
    bit  rv_pend;
    req_cnt = 0;
    rv_pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      gnt_s = 1'b0;
      r_valid_s = 1'b0;
      if (rv_pend && !rv_block) begin
        r_valid_s = 1'b1;
        r_opc_s   = cur_opc;
        r_rdata_s = cur_rdata;
        rv_pend   = 1'b0;
      end
      if (tcdm_req.req) begin
        if (req_cnt >= gnt_delay) begin
          gnt_s   = 1'b1;
          rv_pend = 1'b1;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // AXI master ready side: optional stall before accepting B/R.
  initial begin : axi_ready_model
    int rcnt;
    int bcnt;
    rcnt = 0;
    bcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (axi_rsp.r_valid) begin
        if (rcnt >= r_stall) r_ready_s = 1'b1;
        else begin r_ready_s = 1'b0; rcnt++; end
      end else begin
        rcnt = 0;
        r_ready_s = (r_stall == 0);
      end
      if (axi_rsp.b_valid) begin
        if (bcnt >= b_stall) b_ready_s = 1'b1;
        else begin b_ready_s = 1'b0; bcnt++; end
      end else begin
        bcnt = 0;
        b_ready_s = (b_stall == 0);
      end
    end
  end

  // Monitor: compares every DUT presentation against the head of the scoreboard queues.
  initial begin : monitor
    int    treq_cycles;
    int    accept_cyc;
    bit    lat_done;
    treq_t t;
    rsp_t  e;
    treq_cycles = 0;
    accept_cyc  = 0;
    lat_done    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        treq_cycles = 0;
        lat_done    = 1'b0;
      end else begin
        if (axi_rsp.aw_ready || axi_rsp.w_ready) begin
          chk("aw_w_ready_pair", 32'({axi_rsp.aw_ready, axi_rsp.w_ready, aw_valid_s, w_valid_s, axi_rsp.ar_ready}), 32'h1E);
          accept_cyc = cyc;
          lat_done   = 1'b0;
        end
        if (axi_rsp.ar_ready) begin
          chk("ar_ready_valid", 32'({axi_rsp.ar_ready, ar_valid_s}), 32'h3);
          accept_cyc = cyc;
          lat_done   = 1'b0;
        end
        if (tcdm_req.req) begin
          if (treq_q.size() == 0) begin
            chk("tcdm_unexpected_req", 32'(tcdm_req.add), 32'hFFFF_FFFF);
          end else begin
            t = treq_q[0];
            treq_cycles++;
            chk("tcdm_add", tcdm_req.add, t.add);
            chk("tcdm_wen_be", 32'({tcdm_req.wen, tcdm_req.be}), 32'({t.wen, t.be}));
            if (!t.wen) chk("tcdm_wdata", tcdm_req.wdata, t.wdata);
            if (tcdm_rsp.gnt) begin
              chk("tcdm_req_cycles", 32'(treq_cycles), 32'(t.cyc));
              void'(treq_q.pop_front());
              treq_cycles = 0;
            end
          end
        end
        if (axi_rsp.b_valid || axi_rsp.r_valid) begin
          if (rsp_q.size() == 0) begin
            chk("resp_unexpected", 32'({axi_rsp.b_valid, axi_rsp.r_valid}), 32'h0);
          end else begin
            e = rsp_q[0];
            chk("resp_channel", 32'({axi_rsp.b_valid, axi_rsp.r_valid}), e.is_wr ? 32'h2 : 32'h1);
            if (!lat_done) begin
              chk("resp_latency", 32'(cyc - accept_cyc), 32'(e.lat));
              lat_done = 1'b1;
            end
            if (e.is_wr) begin
              chk("b_resp", 32'(axi_rsp.b_resp), 32'(e.resp));
              if (b_ready_s) void'(rsp_q.pop_front());
            end else begin
              chk("r_resp", 32'(axi_rsp.r_resp), 32'(e.resp));
              chk("r_data", axi_rsp.r_data, e.data);
              if (r_ready_s) void'(rsp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bit got = 1'b0;
    aw_addr_s = a; w_data_s = d; w_strb_s = s;
    aw_valid_s = 1'b1; w_valid_s = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = axi_rsp.aw_ready && axi_rsp.w_ready;
      n++;
    end
    chk("write_accepted", 32'(got), 32'h1);
    @(posedge clk); #1;
    aw_valid_s = 1'b0; w_valid_s = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a);
    int n = 0;
    bit got = 1'b0;
    ar_addr_s = a;
    ar_valid_s = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = axi_rsp.ar_ready;
      n++;
    end
    chk("read_accepted", 32'(got), 32'h1);
    @(posedge clk); #1;
    ar_valid_s = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rsp_q.size() != 0 || treq_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(rsp_q.size() + treq_q.size()), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    ar_valid_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'({axi_rsp.aw_ready, axi_rsp.w_ready, axi_rsp.ar_ready}), 32'h0);
    chk("rst_valid", 32'({axi_rsp.b_valid, axi_rsp.r_valid}), 32'h0);
    chk("rst_resp", 32'({axi_rsp.b_resp, axi_rsp.r_resp}), 32'h0);
    chk("rst_rdata", axi_rsp.r_data, 32'h0);
    chk("rst_tcdm_ctl", 32'({tcdm_req.req, tcdm_req.wen, tcdm_req.be}), 32'h10);
    chk("rst_tcdm_add", tcdm_req.add, 32'h0);
    chk("rst_tcdm_wdata", tcdm_req.wdata, 32'h0);
    ar_valid_s = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write, immediate grant, minimum latency.
    treq_q.push_back('{32'h10, 1'b0, 32'hDEAD_BEEF, 4'b0110, 1});
    rsp_q.push_back('{1'b1, 2'b00, 32'h0, 3});
    axi_write(TB_BASE + 32'h10, 32'hDEAD_BEEF, 4'b0110);
    wait_drain();

    // Read, grant delayed 4 cycles, R stalled 3 cycles.
    gnt_delay = 4; r_stall = 3; cur_rdata = 32'h1234_5678;
    treq_q.push_back('{32'h20, 1'b1, 32'h0, 4'hF, 5});
    rsp_q.push_back('{1'b0, 2'b00, 32'h1234_5678, 7});
    axi_read(TB_BASE + 32'h20);
    wait_drain();
    gnt_delay = 0; r_stall = 0;

    // Error opcode on read and write; B stalled 2 cycles on the write.
    cur_opc = 1'b1; cur_rdata = 32'hCAFE_F00D;
    treq_q.push_back('{32'h44, 1'b1, 32'h0, 4'hF, 1});
    rsp_q.push_back('{1'b0, 2'b10, 32'hCAFE_F00D, 3});
    axi_read(TB_BASE + 32'h44);
    wait_drain();
    b_stall = 2;
    treq_q.push_back('{32'h48, 1'b0, 32'h0BAD_C0DE, 4'hF, 1});
    rsp_q.push_back('{1'b1, 2'b10, 32'h0, 3});
    axi_write(TB_BASE + 32'h48, 32'h0BAD_C0DE, 4'hF);
    wait_drain();
    b_stall = 0; cur_opc = 1'b0;

    // Reset during TWAIT; the late r_valid must not produce a response.
    rv_block = 1'b1; cur_rdata = 32'hBAD0_BAD0;
    treq_q.push_back('{32'h80, 1'b1, 32'h0, 4'hF, 1});
    axi_read(TB_BASE + 32'h80);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tcdm_ctl", 32'({tcdm_req.req, tcdm_req.wen, tcdm_req.be}), 32'h10);
    chk("midrst_tcdm_add", tcdm_req.add, 32'h0);
    chk("midrst_valid", 32'({axi_rsp.b_valid, axi_rsp.r_valid}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rv_block = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_idle", 32'({tcdm_req.req, axi_rsp.b_valid, axi_rsp.r_valid}), 32'h0);
    cur_rdata = 32'h0F0F_1234;
    treq_q.push_back('{32'h84, 1'b1, 32'h0, 4'hF, 1});
    rsp_q.push_back('{1'b0, 2'b00, 32'h0F0F_1234, 3});
    axi_read(TB_BASE + 32'h84);
    wait_drain();

    // Simultaneous write and read pending, twice: W R W R.
    cur_rdata = 32'h5A5A_5A5A;
    treq_q.push_back('{32'h100, 1'b0, 32'h1111_1111, 4'hF, 1});
    treq_q.push_back('{32'h104, 1'b1, 32'h0, 4'hF, 1});
    treq_q.push_back('{32'h108, 1'b0, 32'h2222_2222, 4'b1001, 1});
    treq_q.push_back('{32'h10C, 1'b1, 32'h0, 4'hF, 1});
    rsp_q.push_back('{1'b1, 2'b00, 32'h0, 3});
    rsp_q.push_back('{1'b0, 2'b00, 32'h5A5A_5A5A, 3});
    rsp_q.push_back('{1'b1, 2'b00, 32'h0, 3});
    rsp_q.push_back('{1'b0, 2'b00, 32'h5A5A_5A5A, 3});
    fork
      begin
        axi_write(TB_BASE + 32'h100, 32'h1111_1111, 4'hF);
        axi_write(TB_BASE + 32'h108, 32'h2222_2222, 4'b1001);
      end
      begin
        axi_read(TB_BASE + 32'h104);
        axi_read(TB_BASE + 32'h10C);
      end
    join
    wait_drain();

`ifdef AXI2TCDM_RANGE_CHECK_EN
    // Out-of-window read returns DECERR without touching TCDM; last in-window word forwards.
    rsp_q.push_back('{1'b0, 2'b11, 32'h0, 1});
    axi_read(32'h0000_1100);
    wait_drain();
    cur_rdata = 32'h7777_0001;
    treq_q.push_back('{32'hFC, 1'b1, 32'h0, 4'hF, 1});
    rsp_q.push_back('{1'b0, 2'b00, 32'h7777_0001, 3});
    axi_read(32'h0000_10FC);
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_to_tcdm.md
AXI_LITE_TO_TCDM -- requirements
Module: axi_lite_to_tcdm

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, AXI address mapped to TCDM address 0.
REQ-002 SHALL have parameter REGION_SIZE, default 32'h0001_0000, byte size of the decoded window (used only under REQ-025).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port axi_req_i, input, axi_lite_req_t, AXI-lite slave request (AW, W, B-ready, AR, R-ready).
REQ-006 SHALL have port axi_rsp_o, output, axi_lite_resp_t, AXI-lite slave response (AW/W/AR ready, B, R).
REQ-007 SHALL have port tcdm_req_o, output, tcdm_req_t, TCDM master request {req, add, wen, wdata, be}.
REQ-008 SHALL have port tcdm_rsp_i, input, tcdm_rsp_t, TCDM response {gnt, r_opc, r_rdata, r_valid}.

Function
REQ-009 SHALL serve exactly one AXI transaction at a time; FSM states IDLE, TREQ, TWAIT, BRESP, RRESP.
REQ-010 In IDLE, aw_ready and w_ready SHALL assert together only when aw_valid and w_valid are both high; ar_ready only when ar_valid high; at most one channel accepted per cycle.
REQ-011 When write (AW+W) and read (AR) are both pending in IDLE, round-robin SHALL apply: serve the kind not served last; after reset, write wins first.
REQ-012 Acceptance cycle N -> TREQ at N+1 with tcdm req=1, add=axi addr-BASE_ADDR (mod 2^32), wen=0 for write / 1 for read, wdata=w.data, be=w.strb (write) or 4'hF (read).
REQ-013 In TREQ, req, add, wen, wdata, be SHALL stay stable until gnt=1; gnt cycle G -> req=0 and state TWAIT at G+1.
REQ-014 In TWAIT, first r_valid=1 (any cycle after G) SHALL capture r_rdata and r_opc; next state BRESP (write) or RRESP (read).
REQ-015 BRESP: b_valid=1, b.resp=2'b00 if r_opc=0 else 2'b10 (SLVERR); held until b_ready; handshake cycle -> IDLE.
REQ-016 RRESP: r_valid=1, r.data=captured r_rdata, r.resp per REQ-015 rule; held stable until r_ready; handshake -> IDLE.
REQ-017 Minimum latency, accept->B/R valid: 3 cycles (gnt in TREQ first cycle, r_valid the cycle after).
REQ-018 AW/AR prot fields SHALL be ignored; only one of aw/w ready never asserts alone.
REQ-019 tcdm_rsp_i.r_valid outside TWAIT and gnt outside TREQ SHALL be ignored.
REQ-020 All outputs SHALL be driven from registers or state decode only; no combinational path from tcdm_rsp_i to axi_rsp_o or from axi_req_i to tcdm_req_o.
REQ-021 Next accept SHALL be possible in the cycle after a B/R handshake (back-to-back throughput 1 per 4 cycles minimum).

Reset
REQ-022 rst_ni low SHALL immediately force IDLE, all AXI ready/valid=0, b.resp=r.resp=0, r.data=0, tcdm req=0, add=0, wen=1, wdata=0, be=0, round-robin to write-first.
REQ-023 Reset mid-transaction SHALL abandon it: no B/R issued; late TCDM gnt/r_valid ignored per REQ-019.
REQ-024 After rst_ni rises, first acceptance SHALL occur no earlier than the first subsequent rising edge.

Configuration
REQ-025 Macro AXI2TCDM_RANGE_CHECK_EN defined: address outside [BASE_ADDR, BASE_ADDR+REGION_SIZE) SHALL skip TREQ/TWAIT, go from accept directly to BRESP/RRESP with resp=2'b11 (DECERR), r.data=0, no tcdm req.
REQ-026 Macro undefined: no range check; all addresses forwarded per REQ-012; REGION_SIZE unused.

Verification
REQ-027 Write addr 0x10, data 0xDEADBEEF, strb 4'b0110; gnt immediate, r_valid next -> tcdm add=0x10 wen=0 be=0110 wdata=DEADBEEF; b.resp=00 3 cycles after accept.
REQ-028 Read 0x20, gnt delayed 4 cycles, r_rdata=0x12345678 r_opc=0 -> req stable 5 cycles; r.data=0x12345678 resp=00, held until r_ready after 3 stall cycles.
REQ-029 Write and read valid same cycle twice in a row -> first write, then read, then write (round-robin order).
REQ-030 Read with r_opc=1 -> r.resp=2'b10; write with r_opc=1 -> b.resp=2'b10.
REQ-031 rst_ni low during TWAIT, r_valid arrives after release -> no B/R, tcdm req=0, next read completes normally.
REQ-032 With AXI2TCDM_RANGE_CHECK_EN, BASE_ADDR=0x1000, REGION_SIZE=0x100, read 0x1100 -> r.resp=2'b11, data 0, tcdm req never asserted; read 0x10FC -> forwarded to add=0xFC.
